// File: rtl/seq_pattern_generator_if.sv
// Control/status bundle for seq_pattern_generator: burst request inputs and serial outputs.
// The master drives start/pattern/rep_count/gap_len; the slave (generator) drives the rest.
interface seq_pattern_generator_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned REP_W = 8,
    parameter int unsigned GAP_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [REP_W-1:0] rep_count;
    logic [GAP_W-1:0] gap_len;
    logic             x;
    logic             x_valid;
    logic             frame;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, rep_count, gap_len,
        input  x, x_valid, frame, busy, done
    );

    modport slave (
        input  start, pattern, rep_count, gap_len,
        output x, x_valid, frame, busy, done
    );
endinterface

// File: rtl/seq_pattern_generator.sv
// Serial pattern generator: sends a latched PAT_W-bit pattern MSB-first rep_count times with
// gap_len fill cycles between repetitions. Define SEQ_GEN_LFSR_GAP_EN for pseudo-random gap fill.
module seq_pattern_generator #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned REP_W = 8,
    parameter int unsigned GAP_W = 4
) (
    input logic                    clk,
    input logic                    reset,
    seq_pattern_generator_if.slave bus
);
    localparam int unsigned CntW = $clog2(PAT_W);
    localparam logic [CntW-1:0] LastBit = CntW'(PAT_W - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             launch;
    logic             gap_fill;
    logic [PAT_W-1:0] rep_src;
    logic             fill_bit;

`ifdef SEQ_GEN_LFSR_GAP_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign fill_bit = lfsr_q[0];

    // x^8+x^6+x^5+x^4+1, stepped only when a gap cycle is emitted
    always_comb begin
        lfsr_d = lfsr_q;
        if (gap_fill) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end
`else
    assign fill_bit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        reps_d    = reps_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        frame_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        launch    = 1'b0;
        gap_fill  = 1'b0;
        rep_src   = pattern_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    pattern_d = bus.pattern;
                    gap_len_d = bus.gap_len;
                    if (bus.rep_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        reps_d  = bus.rep_count - 1'b1;
                        rep_src = bus.pattern;
                        launch  = 1'b1;
                    end
                end
            end
            StSend: begin
                if (bit_cnt_q != LastBit) begin
                    x_d       = shreg_q[PAT_W-1];
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end else if (reps_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (gap_len_q != '0) begin
                    state_d   = StGap;
                    gap_cnt_d = gap_len_q - 1'b1;
                    gap_fill  = 1'b1;
                end else begin
                    reps_d = reps_q - 1'b1;
                    launch = 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                    gap_fill  = 1'b1;
                end else begin
                    reps_d = reps_q - 1'b1;
                    launch = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered outputs describe the cycle that follows this edge
        if (launch) begin
            state_d   = StSend;
            x_d       = rep_src[PAT_W-1];
            shreg_d   = rep_src << 1;
            bit_cnt_d = '0;
            x_valid_d = 1'b1;
            frame_d   = 1'b1;
            busy_d    = 1'b1;
        end
        if (gap_fill) begin
            x_d    = fill_bit;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            reps_q    <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_GEN_LFSR_GAP_EN
            lfsr_q    <= 8'hA5;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            reps_q    <= reps_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            frame_q   <= frame_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEQ_GEN_LFSR_GAP_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = x_valid_q;
    assign bus.frame   = frame_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_pattern_generator.sv
// Directed bench for seq_pattern_generator: per-cycle vector table plus long-burst counting runs.
// Expected outputs are packed as {x, x_valid, frame, busy, done}.
module tb_seq_pattern_generator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_pattern_generator_if #(.PAT_W(4), .REP_W(8), .GAP_W(4)) bus ();

    seq_pattern_generator #(.PAT_W(4), .REP_W(8), .GAP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       start;
        logic [3:0] pat;
        logic [7:0] rep;
        logic [3:0] gap;
        logic       rst;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [3:0] p, input logic [7:0] r,
                       input logic [3:0] g, input logic rs, input logic [4:0] e);
        vec_t v;
        v.start = s; v.pat = p; v.rep = r; v.gap = g; v.rst = rs; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic [4:0] e);
        add(1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, e);
    endtask

    // One burst from idle; counts status cycles until done, bounded by limit
    task automatic run_count(input string name, input logic [3:0] p, input logic [7:0] r,
                             input logic [3:0] g, input int exp_busy, input int exp_frames,
                             input int exp_valid);
        int  nb = 0;
        int  nf = 0;
        int  nv = 0;
        bit  seen = 0;
        bus.start = 1'b1; bus.pattern = p; bus.rep_count = r; bus.gap_len = g;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1;
                break;
            end
            nb += int'(bus.busy);
            nf += int'(bus.frame);
            nv += int'(bus.x_valid);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout done=0 required done=1 within 5000 cycles", name);
        end
        checks++;
        if (nb != exp_busy) begin
            errors++;
            $display("FAIL %s_busy cycles=%0d required %0d", name, nb, exp_busy);
        end
        checks++;
        if (nf != exp_frames) begin
            errors++;
            $display("FAIL %s_frames count=%0d required %0d", name, nf, exp_frames);
        end
        checks++;
        if (nv != exp_valid) begin
            errors++;
            $display("FAIL %s_valid count=%0d required %0d", name, nv, exp_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [4:0] got;

        // Reset then 0110 x1, no gap
        add(1'b0, 4'b0000, 8'd0, 4'd0, 1'b1, 5'b00000);
        add(1'b0, 4'b0000, 8'd0, 4'd0, 1'b1, 5'b00000);
        add(1'b1, 4'b0110, 8'd1, 4'd0, 1'b0, 5'b01110);
        idle(5'b11010); idle(5'b11010); idle(5'b01010);
        idle(5'b00001); idle(5'b00000);
        // 0110 x3 back-to-back
        add(1'b1, 4'b0110, 8'd3, 4'd0, 1'b0, 5'b01110);
        idle(5'b11010); idle(5'b11010); idle(5'b01010);
        idle(5'b01110); idle(5'b11010); idle(5'b11010); idle(5'b01010);
        idle(5'b01110); idle(5'b11010); idle(5'b11010); idle(5'b01010);
        idle(5'b00001); idle(5'b00000);
        // 1011 x2 with 3-cycle gap of zeros
        add(1'b1, 4'b1011, 8'd2, 4'd3, 1'b0, 5'b11110);
        idle(5'b01010); idle(5'b11010); idle(5'b11010);
        idle(5'b00010); idle(5'b00010); idle(5'b00010);
        idle(5'b11110); idle(5'b01010); idle(5'b11010); idle(5'b11010);
        idle(5'b00001); idle(5'b00000);
        // rep_count 0: done only
        add(1'b1, 4'b0110, 8'd0, 4'd5, 1'b0, 5'b00001);
        idle(5'b00000); idle(5'b00000);
        // Reset on third bit, then immediate restart
        add(1'b1, 4'b0110, 8'd2, 4'd0, 1'b0, 5'b01110);
        idle(5'b11010); idle(5'b11010);
        add(1'b0, 4'b0000, 8'd0, 4'd0, 1'b1, 5'b00000);
        add(1'b1, 4'b0110, 8'd1, 4'd0, 1'b0, 5'b01110);
        idle(5'b11010); idle(5'b11010); idle(5'b01010);
        idle(5'b00001); idle(5'b00000);
        // start held: a new burst follows each done cycle
        add(1'b1, 4'b0110, 8'd1, 4'd0, 1'b0, 5'b01110);
        add(1'b1, 4'b0110, 8'd1, 4'd0, 1'b0, 5'b11010);
        add(1'b1, 4'b0110, 8'd1, 4'd0, 1'b0, 5'b11010);
        add(1'b1, 4'b0110, 8'd1, 4'd0, 1'b0, 5'b01010);
        add(1'b1, 4'b0110, 8'd1, 4'd0, 1'b0, 5'b00001);
        add(1'b1, 4'b0110, 8'd1, 4'd0, 1'b0, 5'b01110);
        idle(5'b11010); idle(5'b11010); idle(5'b01010);
        idle(5'b00001); idle(5'b00000);
        // start and new inputs mid-burst are ignored
        add(1'b1, 4'b1011, 8'd1, 4'd0, 1'b0, 5'b11110);
        add(1'b1, 4'b0000, 8'd5, 4'd2, 1'b0, 5'b01010);
        add(1'b1, 4'b0000, 8'd5, 4'd2, 1'b0, 5'b11010);
        idle(5'b11010);
        idle(5'b00001); idle(5'b00000);

        bus.start = 1'b0; bus.pattern = '0; bus.rep_count = '0; bus.gap_len = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst;
            bus.start     = vecs[i].start;
            bus.pattern   = vecs[i].pat;
            bus.rep_count = vecs[i].rep;
            bus.gap_len   = vecs[i].gap;
            @(posedge clk); #1;
            got = {bus.x, bus.x_valid, bus.frame, bus.busy, bus.done};
            checks++;
            if (got !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d xvfbd got=%b required=%b", i, got, vecs[i].exp);
            end
        end
        reset = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;

        // Maximum repeat count must not wrap: 255*4 busy cycles
        run_count("rep_max", 4'b1001, 8'd255, 4'd0, 1020, 255, 1020);
        // Maximum gap: 2*4 + 15 busy cycles
        run_count("gap_max", 4'b0110, 8'd2, 4'd15, 23, 2, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
